mp_regfile: RTL and testbench
=============================

MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 SHALL define parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL define parameter NREGS, default 16: architectural register count, power of two; AW = log2(NREGS).
REQ-003 SHALL define parameter NRD, default 4: number of read ports.
REQ-004 SHALL define parameter PC_REG, default 15: index returning pc_in instead of storage.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port we, input, 2 bits: bit0 enables write port 0 and bit1 enables write port 1, independently.
REQ-008 SHALL have ports wa0 and wa1, input, AW bits each: write addresses.
REQ-009 SHALL have ports wd0 and wd1, input, DATA_W bits each: write data.
REQ-010 SHALL have port ra, input, NRD*AW bits: packed read addresses; port i occupies [i*AW +: AW].
REQ-011 SHALL have port rd, output, NRD*DATA_W bits: packed read data; port i occupies [i*DATA_W +: DATA_W].
REQ-012 SHALL have port pc_in, input, DATA_W bits: value returned for reads of PC_REG.
REQ-013 SHALL have port pend_set, input, 1 bit: marks register pend_addr as awaiting a multi-cycle result.
REQ-014 SHALL have port pend_addr, input, AW bits: register to mark pending.
REQ-015 SHALL have port hazard, output, NRD bits: bit i high when read port i sources a pending register.
REQ-016 SHALL have port any_pending, output, 1 bit: OR of all pending bits.
REQ-017 SHALL have port dbg_sel, input, AW bits, and port dbg_data, output, DATA_W bits: debug read of the raw stored value, with no bypass and no PC substitution.

Function
REQ-018 SHALL perform all register-file writes on the rising clk edge, replacing the earlier negedge-write scheme.
REQ-019 SHALL ignore any write addressed to PC_REG; storage for PC_REG SHALL remain 0.
REQ-020 SHALL give port 1 priority when both ports write the same address in the same cycle; only wd1 is stored.
REQ-021 SHALL make read port i return pc_in when its address is PC_REG; otherwise wd1 if we[1] is set and wa1 matches; otherwise wd0 if we[0] is set and wa0 matches; otherwise stored data. Same-cycle write-through has zero latency.
REQ-022 SHALL set pending[pend_addr] at the clock edge when pend_set is high and pend_addr is not PC_REG.
REQ-023 SHALL clear pending[a] at the clock edge when an enabled write port targets a.
REQ-024 SHALL give pend_set priority when it targets the same register that a write clears in the same cycle; the bit ends set.
REQ-025 SHALL drive hazard[i] = pending[ra_i] AND NOT (same-cycle enabled write to ra_i); hazard[i] SHALL be 0 for PC_REG.
REQ-026 SHALL keep hazard and rd purely combinational from current inputs and state, with no added latency.
REQ-027 SHALL hold any_pending high while at least one pending bit is set, registered-state based.

Reset
REQ-028 SHALL clear all NREGS storage words to 0 and all pending bits to 0 on a clk edge with reset high.
REQ-029 SHALL give reset priority over simultaneous writes and pend_set; those requests are dropped.
REQ-030 SHALL drive, in the cycle following reset: rd = 0 except pc_in for PC_REG reads; hazard = 0; any_pending = 0; dbg_data = 0.

Structure
REQ-031 SHALL place default DATA_W/NREGS/NRD/PC_REG constants and the write-port-count constant (2) in a shared package pipeline_pkg.
REQ-032 SHALL instantiate one sub-module, rf_read_port (address in, forwarding and PC mux, hazard out), NRD times via generate.
REQ-033 SHALL hold storage and pending bits in mp_regfile only, so that rf_read_port is purely combinational.

Verification
REQ-034 SHALL cover: reset, then read all 16 registers -> 0, except r15, which returns pc_in = 0x0000_1000.
REQ-035 SHALL cover: we=2'b11 with wa0=wa1=3, wd0=0xAAAA_AAAA, wd1=0x5555_5555 -> same-cycle rd of r3 = 0x5555_5555, and next cycle stored value 0x5555_5555.
REQ-036 SHALL cover: we=2'b01 with wa0=15, wd0=0xDEAD_BEEF -> dbg_sel=15 gives 0, and a read of 15 gives pc_in.
REQ-037 SHALL cover: pend_set on r4, then read r4 -> hazard=1 and any_pending=1; next, we[0] writes r4=0x1234 -> same-cycle hazard=0 with rd=0x1234, and next cycle any_pending=0.
REQ-038 SHALL cover: pend_set on r5 with simultaneous write to r5 -> r5 stays pending while the data is stored.
REQ-039 SHALL cover: reset asserted with we=2'b11 and pend_set active -> no write lands and no pending bit is set.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared defaults for the register file and its read ports.
package pipeline_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 16;
  localparam int NRD_DEF    = 4;
  localparam int PC_REG_DEF = 15;
  localparam int NWP        = 2;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: PC substitution, write-through forwarding, hazard.
module rf_read_port
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = 4,
  parameter int PC_REG = PC_REG_DEF
) (
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] stored,
  input  logic              pend,
  input  logic [NWP-1:0]    we,
  input  logic [AW-1:0]     wa0,
  input  logic [AW-1:0]     wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] data,
  output logic              hazard
);
  localparam logic [AW-1:0] PC_A = AW'(PC_REG);

  logic is_pc, hit0, hit1;

  assign is_pc = (addr == PC_A);
  assign hit0  = we[0] && (wa0 == addr);
  assign hit1  = we[1] && (wa1 == addr);

  // Port 1 wins over port 0, matching the storage write order.
  always_comb begin
    if (is_pc)     data = pc_in;
    else if (hit1) data = wd1;
    else if (hit0) data = wd0;
    else           data = stored;
  end

  assign hazard = pend && !hit0 && !hit1 && !is_pc;
endmodule

// File: rtl/mp_regfile.sv
// Two-write, NRD-read register file with pending-result scoreboard and PC alias.
module mp_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int PC_REG = PC_REG_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NWP-1:0]        we,
  input  logic [AW-1:0]         wa0,
  input  logic [AW-1:0]         wa1,
  input  logic [DATA_W-1:0]     wd0,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic                  pend_set,
  input  logic [AW-1:0]         pend_addr,
  output logic [NRD-1:0]        hazard,
  output logic                  any_pending,
  input  logic [AW-1:0]         dbg_sel,
  output logic [DATA_W-1:0]     dbg_data
);
  localparam logic [AW-1:0] PC_A = AW'(PC_REG);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0]             pending;
  logic [NREGS-1:0]             pend_nxt;

  // A new pend_set outranks a same-cycle clear of the same register.
  always_comb begin
    pend_nxt = pending;
    if (we[0]) pend_nxt[wa0] = 1'b0;
    if (we[1]) pend_nxt[wa1] = 1'b0;
    if (pend_set && pend_addr != PC_A) pend_nxt[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs    <= '0;
      pending <= '0;
    end else begin
      if (we[0] && wa0 != PC_A) regs[wa0] <= wd0;
      if (we[1] && wa1 != PC_A) regs[wa1] <= wd1;
      pending <= pend_nxt;
    end
  end

  assign any_pending = |pending;
  assign dbg_data    = regs[dbg_sel];

  for (genvar i = 0; i < NRD; i++) begin : g_rp
    logic [AW-1:0] addr;
    assign addr = ra[i*AW +: AW];

    rf_read_port #(.DATA_W(DATA_W), .AW(AW), .PC_REG(PC_REG)) u_rp (
      .addr   (addr),
      .pc_in  (pc_in),
      .stored (regs[addr]),
      .pend   (pending[addr]),
      .we     (we),
      .wa0    (wa0),
      .wa1    (wa1),
      .wd0    (wd0),
      .wd1    (wd1),
      .data   (rd[i*DATA_W +: DATA_W]),
      .hazard (hazard[i])
    );
  end
endmodule

// File: tb/tb_mp_regfile.sv
// Directed vector table plus randomized run against an array-based reference model.
module tb_mp_regfile;
  localparam int NRD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  we;
  logic [3:0]  wa0, wa1, pend_addr, dbg_sel;
  logic [31:0] wd0, wd1, pc_in, dbg_data;
  logic [15:0] ra;
  logic [127:0] rd;
  logic        pend_set, any_pending;
  logic [3:0]  hazard;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [16];
  bit          m_pend [16];

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [3:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ps;
    logic [3:0]  pa, ra, dbg;
    logic [31:0] e_rd;
    logic        e_hz, e_ap;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t tbl [16];

  mp_regfile dut (
    .clk(clk), .reset(reset), .we(we), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra), .rd(rd), .pc_in(pc_in), .pend_set(pend_set), .pend_addr(pend_addr),
    .hazard(hazard), .any_pending(any_pending), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [1:0] w, logic [3:0] a0, logic [3:0] a1,
                              logic [31:0] d0, logic [31:0] d1, logic ps, logic [3:0] pa,
                              logic [3:0] r, logic [3:0] dbg, logic [31:0] erd,
                              logic ehz, logic eap, logic [31:0] edbg);
    vec_t v;
    v.rst = rst; v.we = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.ps = ps; v.pa = pa; v.ra = r; v.dbg = dbg;
    v.e_rd = erd; v.e_hz = ehz; v.e_ap = eap; v.e_dbg = edbg;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: architectural rules applied on the current inputs and model state.
  task automatic model_check(input string tag);
    logic [31:0] e;
    logic [3:0]  a;
    bit          h, ap;
    for (int i = 0; i < NRD; i++) begin
      a = ra[i*4 +: 4];
      if (a == 4'd15)                 e = pc_in;
      else if (we[1] && wa1 == a)     e = wd1;
      else if (we[0] && wa0 == a)     e = wd0;
      else                            e = m_mem[a];
      h = (a != 4'd15) && m_pend[a] && !(we[0] && wa0 == a) && !(we[1] && wa1 == a);
      chk($sformatf("%s rd%0d", tag, i), rd[i*32 +: 32], e);
      chk($sformatf("%s hz%0d", tag, i), {31'd0, hazard[i]}, {31'd0, h});
    end
    ap = 1'b0;
    for (int r = 0; r < 16; r++) ap |= m_pend[r];
    chk({tag, " anyp"}, {31'd0, any_pending}, {31'd0, ap});
    chk({tag, " dbg"}, dbg_data, m_mem[dbg_sel]);
  endtask

  task automatic model_step();
    if (reset) begin
      for (int r = 0; r < 16; r++) begin m_mem[r] = '0; m_pend[r] = 1'b0; end
    end else begin
      if (we[0] && wa0 != 4'd15) m_mem[wa0] = wd0;
      if (we[1] && wa1 != 4'd15) m_mem[wa1] = wd1;
      if (we[0]) m_pend[wa0] = 1'b0;
      if (we[1]) m_pend[wa1] = 1'b0;
      if (pend_set && pend_addr != 4'd15) m_pend[pend_addr] = 1'b1;
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; we = v.we; wa0 = v.wa0; wa1 = v.wa1; wd0 = v.wd0; wd1 = v.wd1;
    pend_set = v.ps; pend_addr = v.pa; dbg_sel = v.dbg; ra = {4{v.ra}};
  endtask

  initial begin
    pc_in = 32'h0000_1000;
    tbl[0]  = mk(0, 2'b11, 3, 3, 32'hAAAA_AAAA, 32'h5555_5555, 0, 0, 3, 3, 32'h5555_5555, 0, 0, 0);
    tbl[1]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3, 32'h5555_5555, 0, 0, 32'h5555_5555);
    tbl[2]  = mk(0, 2'b01, 15, 0, 32'hDEAD_BEEF, 0, 0, 0, 15, 15, 32'h1000, 0, 0, 0);
    tbl[3]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 15, 15, 32'h1000, 0, 0, 0);
    tbl[4]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 4, 0, 0, 0, 0);
    tbl[5]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 0, 1, 1, 0);
    tbl[6]  = mk(0, 2'b01, 4, 0, 32'h1234, 0, 0, 0, 4, 4, 32'h1234, 0, 1, 0);
    tbl[7]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 32'h1234, 0, 0, 32'h1234);
    tbl[8]  = mk(0, 2'b01, 5, 0, 32'h55, 0, 1, 5, 5, 5, 32'h55, 0, 0, 0);
    tbl[9]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 32'h55, 1, 1, 32'h55);
    tbl[10] = mk(0, 2'b00, 0, 0, 0, 0, 1, 15, 15, 15, 32'h1000, 0, 1, 0);
    tbl[11] = mk(0, 2'b01, 5, 0, 32'h66, 0, 0, 0, 5, 5, 32'h66, 0, 1, 32'h55);
    tbl[12] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 15, 15, 32'h1000, 0, 0, 0);
    tbl[13] = mk(0, 2'b00, 0, 0, 0, 0, 1, 7, 7, 7, 0, 0, 0, 0);
    tbl[14] = mk(0, 2'b10, 0, 7, 0, 32'h77, 0, 0, 7, 7, 32'h77, 0, 1, 0);
    tbl[15] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 32'h77, 0, 0, 32'h77);

    // Reset with writes and pend_set in flight: all of it must be dropped.
    @(negedge clk);
    apply(mk(1, 2'b11, 1, 2, 32'h1111, 32'h2222, 1, 6, 0, 0, 0, 0, 0, 0));
    #1 model_step();
    @(negedge clk);
    apply(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int r = 0; r < 16; r++) begin
      ra = {4{r[3:0]}}; dbg_sel = r[3:0];
      #1;
      for (int i = 0; i < NRD; i++)
        chk($sformatf("rst r%0d p%0d", r, i), rd[i*32 +: 32], (r == 15) ? 32'h1000 : 32'h0);
      chk($sformatf("rst hz r%0d", r), {28'd0, hazard}, 32'd0);
      chk($sformatf("rst dbg r%0d", r), dbg_data, 32'd0);
    end
    chk("rst anyp", {31'd0, any_pending}, 32'd0);

    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      apply(tbl[k]);
      #1;
      for (int i = 0; i < NRD; i++)
        chk($sformatf("vec%0d rd%0d", k, i), rd[i*32 +: 32], tbl[k].e_rd);
      chk($sformatf("vec%0d hz", k), {28'd0, hazard}, {28'd0, {4{tbl[k].e_hz}}});
      chk($sformatf("vec%0d anyp", k), {31'd0, any_pending}, {31'd0, tbl[k].e_ap});
      chk($sformatf("vec%0d dbg", k), dbg_data, tbl[k].e_dbg);
      model_step();
    end

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 31) == 0);
      we        = 2'($urandom_range(0, 3));
      wa0       = 4'($urandom_range(0, 15));
      wa1       = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom_range(0, 15));
      wd0       = $urandom;
      wd1       = $urandom;
      pend_set  = $urandom_range(0, 1) == 1;
      pend_addr = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom_range(0, 15));
      dbg_sel   = 4'($urandom_range(0, 15));
      pc_in     = $urandom;
      for (int i = 0; i < NRD; i++)
        ra[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? wa1 : 4'($urandom_range(0, 15));
      #1 model_check($sformatf("rnd%0d", n));
      model_step();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
